// File: rtl/edge_pix_out_serdes_if.sv
// Bus interface for edge_pix_out_serdes.
//   i_pix_data/i_vsync/i_hsync/i_de/i_valid : pixel word plus sync flags from the core
//   i_clr_err                               : clears the sticky underrun flag
//   o_ready                                 : FIFO can accept a word this cycle
//   o_pix_data/o_vsync/o_hsync/o_de         : pad lanes and flags of the word being emitted
//   o_pclk/o_beat0/o_underrun               : pixel clock, beat-0 marker, sticky error
// master = core side (drives i_*), slave = serializer (drives o_*).
interface edge_pix_out_serdes_if #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned PAD_W  = 12
);
    logic [DATA_W-1:0] i_pix_data;
    logic              i_vsync;
    logic              i_hsync;
    logic              i_de;
    logic              i_valid;
    logic              i_clr_err;
    logic              o_ready;
    logic [PAD_W-1:0]  o_pix_data;
    logic              o_vsync;
    logic              o_hsync;
    logic              o_de;
    logic              o_pclk;
    logic              o_beat0;
    logic              o_underrun;

    modport master (
        output i_pix_data, i_vsync, i_hsync, i_de, i_valid, i_clr_err,
        input  o_ready, o_pix_data, o_vsync, o_hsync, o_de, o_pclk, o_beat0, o_underrun
    );

    modport slave (
        input  i_pix_data, i_vsync, i_hsync, i_de, i_valid, i_clr_err,
        output o_ready, o_pix_data, o_vsync, o_hsync, o_de, o_pclk, o_beat0, o_underrun
    );
endinterface

// File: rtl/edge_pix_out_serdes.sv
// Pixel output serializer: buffers {vsync,hsync,de,data} words in a small FIFO and emits
// each word over PAD_W pad lanes in BEATS beats, LSB slice first, with a generated pixel
// clock (CLK_DIV core cycles per beat). When no word is available at a word boundary a
// blank word (data 0, de 0, syncs held) is sent; starving an active (de=1) stream raises
// a sticky underrun flag.
// Ports:
//   clk   : core clock, all logic on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of edge_pix_out_serdes_if (input word/handshake, pad outputs)
module edge_pix_out_serdes #(
    parameter int unsigned DATA_W  = 24,
    parameter int unsigned PAD_W   = 12,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned CLK_DIV = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    edge_pix_out_serdes_if.slave bus
);
    localparam int unsigned BEATS   = (DATA_W + PAD_W - 1) / PAD_W;
    localparam int unsigned SR_W    = BEATS * PAD_W;
    localparam int unsigned ENTRY_W = DATA_W + 3;
    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned DIV_W   = $clog2(CLK_DIV);
    localparam int unsigned BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    // FIFO
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [AW:0]        count_q;
    logic               full, empty, push, pop;
    logic [ENTRY_W-1:0] rd_entry;

    // Beat timing
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic              div_last, beat_last, word_end;

    // FSM and datapath
    state_e            state_q, state_d;
    logic              load_word, load_blank;
    logic [SR_W-1:0]   word_ext;
    logic [SR_W-1:0]   sr_q;
    logic [PAD_W-1:0]  pix_q;
    logic              vsync_q, hsync_q, de_q, pclk_q, beat0_q, underrun_q;

    assign full  = (count_q == (AW + 1)'(DEPTH));
    assign empty = (count_q == '0);
    // Pop decision uses the registered count, so a word pushed this cycle is not poppable
    // until the next one.
    assign push  = bus.i_valid && !full;
    assign pop   = load_word;

    assign rd_entry = mem[rd_ptr_q];
    assign word_ext = SR_W'(rd_entry[DATA_W-1:0]);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {bus.i_vsync, bus.i_hsync, bus.i_de, bus.i_pix_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Free-running beat timing, independent of FIFO contents.
    assign div_last  = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    assign beat_last = (beat_cnt_q == BEAT_W'(BEATS - 1));
    assign word_end  = div_last && beat_last;

    always_comb begin
        div_cnt_d  = div_last ? '0 : div_cnt_q + DIV_W'(1);
        beat_cnt_d = beat_cnt_q;
        if (div_last) begin
            beat_cnt_d = beat_last ? '0 : beat_cnt_q + BEAT_W'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        load_word  = 1'b0;
        load_blank = 1'b0;
        if (word_end) begin
            if (!empty) begin
                state_d   = StActive;
                load_word = 1'b1;
            end else begin
                state_d    = StIdle;
                load_blank = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            div_cnt_q  <= '0;
            beat_cnt_q <= '0;
            sr_q       <= '0;
            pix_q      <= '0;
            vsync_q    <= 1'b0;
            hsync_q    <= 1'b0;
            de_q       <= 1'b0;
            pclk_q     <= 1'b0;
            beat0_q    <= 1'b1;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            // Registered from next-state counters so pclk/beat0 line up with div/beat.
            pclk_q     <= (div_cnt_d >= DIV_W'(CLK_DIV / 2));
            beat0_q    <= (beat_cnt_d == '0);

            if (load_word) begin
                pix_q   <= word_ext[PAD_W-1:0];
                sr_q    <= word_ext >> PAD_W;
                vsync_q <= rd_entry[DATA_W+2];
                hsync_q <= rd_entry[DATA_W+1];
                de_q    <= rd_entry[DATA_W];
            end else if (load_blank) begin
                // Blank word: lanes and de go low, syncs keep their last value.
                pix_q <= '0;
                sr_q  <= '0;
                de_q  <= 1'b0;
            end else if (div_last) begin
                pix_q <= sr_q[PAD_W-1:0];
                sr_q  <= sr_q >> PAD_W;
            end

            // de_q still holds the flag of the word that just finished; set beats clear.
            if (load_blank && de_q) begin
                underrun_q <= 1'b1;
            end else if (bus.i_clr_err) begin
                underrun_q <= 1'b0;
            end
        end
    end

    assign bus.o_ready    = !full;
    assign bus.o_pix_data = pix_q;
    assign bus.o_vsync    = vsync_q;
    assign bus.o_hsync    = hsync_q;
    assign bus.o_de       = de_q;
    assign bus.o_pclk     = pclk_q;
    assign bus.o_beat0    = beat0_q;
    assign bus.o_underrun = underrun_q;
endmodule
